mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage driving a 16-bit SRAM as two halfword accesses per 32-bit word
// Optional feature: MEM_ADDR_CHECK_EN enables out-of-range address rejection and addr_err.
module mem_stage #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [3:0]  dest_out,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        cnt_last;
  logic [16:0] word;
  logic        borrow;
  logic        req_raw;
  logic        addr_bad;
  logic        req;
  logic        wr_q;
  logic [15:0] lo_q;

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  // Word index of (alu_res_in - BASE_ADDR); only bits [18:2] of the difference
  // matter, so the low two bits contribute just their borrow.
  assign borrow   = alu_res_in[1:0] < BASE_ADDR[1:0];
  assign word     = alu_res_in[18:2] - BASE_ADDR[18:2] - {16'd0, borrow};
  assign req_raw  = mem_r_en_in | mem_w_en_in;
  assign cnt_last = (cnt == CNT_LAST);

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = (alu_res_in < BASE_ADDR) || ((alu_res_in - BASE_ADDR) >= 32'h0008_0000);
`else
  assign addr_bad = 1'b0;
`endif

  // A rejected address never becomes an SRAM request.
  assign req = req_raw & ~addr_bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> LO -> HI -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_LO;
      S_LO:    if (cnt_last) state_nxt = S_HI;
      S_HI:    if (cnt_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: stall upstream while an access is in flight
  always_comb begin
    ready    = 1'b0;
    addr_err = 1'b0;
    case (state)
      S_IDLE: begin
        ready    = ~req;
        addr_err = req_raw & addr_bad & ~rst;
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Wait counter: counts cycles spent in the current half access
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE:      cnt <= 4'd0;
        S_LO, S_HI:  cnt <= cnt_last ? 4'd0 : cnt + 4'd1;
        default:     cnt <= 4'd0;
      endcase
    end
  end

  // SRAM port registers: loaded on entry to each half, held elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr  <= 18'd0;
      sram_wdata <= 16'd0;
      sram_we_n  <= 1'b1;
      wr_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            sram_addr <= {word, 1'b0};
            wr_q      <= mem_w_en_in;
            if (mem_w_en_in) begin
              sram_we_n  <= 1'b0;
              sram_wdata <= val_rm_in[15:0];
            end
          end
        end
        S_LO: begin
          if (cnt_last) begin
            sram_addr <= {word, 1'b1};
            if (wr_q) sram_wdata <= val_rm_in[31:16];
          end
        end
        S_HI: begin
          if (cnt_last) sram_we_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read capture: low half at end of LO, full word published on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q       <= 16'd0;
      mem_result <= 32'd0;
    end else begin
      if (state == S_LO && cnt_last) lo_q <= sram_rdata;
      if (state == S_HI && cnt_last && !wr_q) mem_result <= {sram_rdata, lo_q};
    end
  end

endmodule
